// File: rtl/xspi_8s_crc_target_if.sv
// Octal-SPI (8S-8S-8S) bus between a host and the CRC-checked memory target.
interface xspi_8s_crc_target_if;
    logic       cs_n;
    logic [7:0] dq_in;
    logic [7:0] dq_out;
    logic       dq_oe;
    logic       frame_done;
    logic       crc_err;
    logic [7:0] crc_err_cnt;

    modport master (
        output cs_n, dq_in,
        input  dq_out, dq_oe, frame_done, crc_err, crc_err_cnt
    );

    modport slave (
        input  cs_n, dq_in,
        output dq_out, dq_oe, frame_done, crc_err, crc_err_cnt
    );
endinterface

// File: rtl/xspi_8s_crc_target.sv
// Octal-SPI target: receives CRC-8 protected write/read frames, answers ACK/NAK,
// and serves 64-bit words from an internal memory with a trailing CRC-8.
module xspi_8s_crc_target #(
    parameter int unsigned ADDR_BYTES   = 4,
    parameter int unsigned DATA_BYTES   = 8,
    parameter int unsigned DEPTH        = 512,
    parameter int unsigned DUMMY_CYCLES = 2,
    parameter logic [7:0]  ACK_BYTE     = 8'hA5,
    parameter logic [7:0]  NAK_BYTE     = 8'h5A
) (
    input  logic                   clk,
    input  logic                   rst,
    xspi_8s_crc_target_if.slave    bus
);

    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned AK     = IDX_W + 3;
    localparam int unsigned DW     = DATA_BYTES * 8;
    localparam int unsigned CNT_W  = 8;
    localparam logic [7:0]  CMD_WR = 8'h02;
    localparam logic [7:0]  CMD_RD = 8'h0B;

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_WDATA, S_RXCRC, S_TURN,
        S_STATUS, S_RDATA, S_TXCRC, S_DONE, S_IGNORE
    } state_t;

    // CRC-8, poly 0x07, MSB first, one byte per call
    function automatic logic [7:0] crc8_upd(input logic [7:0] crc, input logic [7:0] b);
        logic [7:0] c;
        c = crc ^ b;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wr_q, wr_d;
    logic [AK-1:0]      addr_q, addr_d;
    logic [DW-1:0]      wdata_q, wdata_d;
    logic [DW-1:0]      sh_q, sh_d;
    logic [7:0]         crc_q, crc_d;
    logic               crc_ok_q, crc_ok_d;
    logic [7:0]         dq_out_q, dq_out_d;
    logic               dq_oe_q, dq_oe_d;
    logic               frame_done_q, frame_done_d;
    logic               crc_err_q, crc_err_d;
    logic [7:0]         crc_err_cnt_q, crc_err_cnt_d;
    logic               mem_we;

    logic [DW-1:0]      mem [DEPTH];
    logic [IDX_W-1:0]   idx;
    logic [DW-1:0]      rd_word;

    // Only the address bits that select a word are kept; the rest shift out.
    assign idx     = addr_q[AK-1:3];
    assign rd_word = mem[idx];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            wr_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            sh_q          <= '0;
            crc_q         <= '0;
            crc_ok_q      <= 1'b0;
            dq_out_q      <= '0;
            dq_oe_q       <= 1'b0;
            frame_done_q  <= 1'b0;
            crc_err_q     <= 1'b0;
            crc_err_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wr_q          <= wr_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            sh_q          <= sh_d;
            crc_q         <= crc_d;
            crc_ok_q      <= crc_ok_d;
            dq_out_q      <= dq_out_d;
            dq_oe_q       <= dq_oe_d;
            frame_done_q  <= frame_done_d;
            crc_err_q     <= crc_err_d;
            crc_err_cnt_q <= crc_err_cnt_d;
        end
    end

    // Memory is not reset; a reset edge suppresses any pending write.
    always_ff @(posedge clk) begin
        if (rst && mem_we) begin
            mem[idx] <= wdata_q;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        wr_d          = wr_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        sh_d          = sh_q;
        crc_d         = crc_q;
        crc_ok_d      = crc_ok_q;
        dq_out_d      = 8'h00;
        dq_oe_d       = 1'b0;
        frame_done_d  = 1'b0;
        crc_err_d     = 1'b0;
        crc_err_cnt_d = crc_err_cnt_q;
        mem_we        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!bus.cs_n) begin
                    crc_d = crc8_upd(8'h00, bus.dq_in);
                    cnt_d = '0;
                    wr_d  = (bus.dq_in == CMD_WR);
                    if (bus.dq_in == CMD_WR || bus.dq_in == CMD_RD) begin
                        state_d = S_ADDR;
                    end else begin
                        state_d = S_IGNORE;
                    end
                end
            end
            S_ADDR: begin
                addr_d = {addr_q[AK-9:0], bus.dq_in};
                crc_d  = crc8_upd(crc_q, bus.dq_in);
                if (cnt_q == CNT_W'(ADDR_BYTES - 1)) begin
                    cnt_d   = '0;
                    state_d = wr_q ? S_WDATA : S_RXCRC;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WDATA: begin
                wdata_d = {wdata_q[DW-9:0], bus.dq_in};
                crc_d   = crc8_upd(crc_q, bus.dq_in);
                if (cnt_q == CNT_W'(DATA_BYTES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_RXCRC;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RXCRC: begin
                crc_ok_d = (bus.dq_in == crc_q);
                if (bus.dq_in != crc_q) begin
                    crc_err_d = 1'b1;
                    if (crc_err_cnt_q != 8'hFF) begin
                        crc_err_cnt_d = crc_err_cnt_q + 8'd1;
                    end
                end
                cnt_d   = '0;
                state_d = S_TURN;
            end
            S_TURN: begin
                if (cnt_q == CNT_W'(DUMMY_CYCLES - 1)) begin
                    state_d  = S_STATUS;
                    dq_oe_d  = 1'b1;
                    dq_out_d = crc_ok_q ? ACK_BYTE : NAK_BYTE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STATUS: begin
                if (crc_ok_q && !wr_q) begin
                    // Snapshot the word now so later writes cannot tear the reply.
                    sh_d     = {rd_word[DW-9:0], 8'h00};
                    dq_out_d = rd_word[DW-1 -: 8];
                    dq_oe_d  = 1'b1;
                    crc_d    = crc8_upd(8'h00, rd_word[DW-1 -: 8]);
                    cnt_d    = '0;
                    state_d  = S_RDATA;
                end else begin
                    mem_we       = crc_ok_q && wr_q;
                    frame_done_d = 1'b1;
                    state_d      = S_DONE;
                end
            end
            S_RDATA: begin
                dq_oe_d = 1'b1;
                if (cnt_q == CNT_W'(DATA_BYTES - 1)) begin
                    dq_out_d = crc_q;
                    state_d  = S_TXCRC;
                end else begin
                    dq_out_d = sh_q[DW-1 -: 8];
                    sh_d     = {sh_q[DW-9:0], 8'h00};
                    crc_d    = crc8_upd(crc_q, sh_q[DW-1 -: 8]);
                    cnt_d    = cnt_q + CNT_W'(1);
                end
            end
            S_TXCRC: begin
                frame_done_d = 1'b1;
                state_d      = S_DONE;
            end
            S_DONE, S_IGNORE: begin
                if (bus.cs_n) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Host deselect mid-frame abandons the transaction without side effects.
        if (bus.cs_n && state_q != S_IDLE && state_q != S_DONE && state_q != S_IGNORE) begin
            state_d       = S_IDLE;
            dq_oe_d       = 1'b0;
            dq_out_d      = 8'h00;
            frame_done_d  = 1'b0;
            crc_err_d     = 1'b0;
            crc_err_cnt_d = crc_err_cnt_q;
            mem_we        = 1'b0;
        end
    end

    assign bus.dq_out      = dq_out_q;
    assign bus.dq_oe       = dq_oe_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.crc_err     = crc_err_q;
    assign bus.crc_err_cnt = crc_err_cnt_q;

endmodule

// File: tb/tb_xspi_8s_crc_target.sv
// Directed bench for the octal-SPI CRC target: writes, reads, CRC errors, abort, reset.
module tb_xspi_8s_crc_target;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;
    logic [7:0] aug;
    logic [7:0] exp_cnt;

    xspi_8s_crc_target_if bus ();

    xspi_8s_crc_target dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Augmented-message CRC-8 (poly 0x07): shift message bits through, flush with zeros.
    function automatic logic [7:0] aug_feed(input logic [7:0] r, input logic [7:0] b);
        logic [7:0] x;
        logic       top;
        x = r;
        for (int i = 7; i >= 0; i--) begin
            top = x[7];
            x   = {x[6:0], b[i]};
            if (top) x = x ^ 8'h07;
        end
        return x;
    endfunction

    function automatic logic [7:0] aug_final(input logic [7:0] r);
        return aug_feed(r, 8'h00);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.cs_n  = 1'b0;
        bus.dq_in = b;
        aug       = aug_feed(aug, b);
        tick();
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [31:0] addr);
        aug = 8'h00;
        send(cmd);
        for (int i = 3; i >= 0; i--) send(addr[8*i +: 8]);
    endtask

    task automatic send_crc(input logic [7:0] flip);
        bus.cs_n  = 1'b0;
        bus.dq_in = aug_final(aug) ^ flip;
        tick();
        bus.dq_in = 8'h00;
    endtask

    // Called right after the CRC beat: two quiet turnaround beats, then status.
    task automatic turn_status(input string tag, input logic bad);
        if (bad && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
        check({tag, ".crc_err"}, 64'(bus.crc_err), 64'(bad));
        check({tag, ".cnt"}, 64'(bus.crc_err_cnt), 64'(exp_cnt));
        check({tag, ".turn1_oe"}, 64'(bus.dq_oe), 64'd0);
        tick();
        check({tag, ".turn2_oe"}, 64'(bus.dq_oe), 64'd0);
        check({tag, ".turn2_err"}, 64'(bus.crc_err), 64'd0);
        tick();
        check({tag, ".stat_oe"}, 64'(bus.dq_oe), 64'd1);
        check({tag, ".stat"}, 64'(bus.dq_out), bad ? 64'h5A : 64'hA5);
    endtask

    task automatic finish_frame(input string tag);
        tick();
        check({tag, ".done_oe"}, 64'(bus.dq_oe), 64'd0);
        check({tag, ".done"}, 64'(bus.frame_done), 64'd1);
        bus.cs_n = 1'b1;
        tick();
        check({tag, ".done_pulse"}, 64'(bus.frame_done), 64'd0);
    endtask

    task automatic wr_frame(input string tag, input logic [31:0] addr,
                            input logic [63:0] data, input logic [7:0] flip);
        send_hdr(8'h02, addr);
        for (int i = 7; i >= 0; i--) send(data[8*i +: 8]);
        send_crc(flip);
        turn_status(tag, flip != 8'h00);
        finish_frame(tag);
    endtask

    task automatic rd_frame(input string tag, input logic [31:0] addr,
                            input logic [7:0] flip, input logic [63:0] expw);
        send_hdr(8'h0B, addr);
        send_crc(flip);
        turn_status(tag, flip != 8'h00);
        if (flip == 8'h00) begin
            aug = 8'h00;
            for (int i = 7; i >= 0; i--) begin
                tick();
                check({tag, ".data_oe"}, 64'(bus.dq_oe), 64'd1);
                check({tag, ".data"}, 64'(bus.dq_out), 64'(expw[8*i +: 8]));
                aug = aug_feed(aug, expw[8*i +: 8]);
            end
            tick();
            check({tag, ".txcrc_oe"}, 64'(bus.dq_oe), 64'd1);
            check({tag, ".txcrc"}, 64'(bus.dq_out), 64'(aug_final(aug)));
        end
        finish_frame(tag);
    endtask

    initial begin
        n_chk     = 0;
        n_err     = 0;
        aug       = 8'h00;
        exp_cnt   = 8'h00;
        rst       = 1'b0;
        bus.cs_n  = 1'b1;
        bus.dq_in = 8'h00;
        tick();
        tick();
        check("rst.dq_oe", 64'(bus.dq_oe), 64'd0);
        check("rst.dq_out", 64'(bus.dq_out), 64'd0);
        check("rst.frame_done", 64'(bus.frame_done), 64'd0);
        check("rst.crc_err", 64'(bus.crc_err), 64'd0);
        check("rst.cnt", 64'(bus.crc_err_cnt), 64'd0);
        rst = 1'b1;
        tick();

        wr_frame("wr_good", 32'h0000_0008, 64'hDEADBEEF_CAFEBABE, 8'h00);
        rd_frame("rd_back", 32'h0000_0008, 8'h00, 64'hDEADBEEF_CAFEBABE);

        wr_frame("wr_bad", 32'h0000_0008, 64'h11223344_55667788, 8'h01);
        rd_frame("rd_after_bad", 32'h0000_0008, 8'h00, 64'hDEADBEEF_CAFEBABE);
        wr_frame("wr_retx", 32'h0000_0008, 64'h11223344_55667788, 8'h00);
        rd_frame("rd_retx", 32'h0000_0008, 8'h00, 64'h11223344_55667788);
        wr_frame("wr_restore", 32'h0000_0008, 64'hDEADBEEF_CAFEBABE, 8'h00);

        rd_frame("rd_bad", 32'h0000_0008, 8'h01, 64'h0);
        for (int i = 0; i < 256; i++) rd_frame("rd_sat", 32'h0000_0008, 8'h80, 64'h0);
        check("sat.cnt", 64'(bus.crc_err_cnt), 64'hFF);

        // Abort a write after three data bytes; the stored word must survive.
        wr_frame("wr_pre_abort", 32'h0000_0010, 64'h01234567_89ABCDEF, 8'h00);
        send_hdr(8'h02, 32'h0000_0010);
        send(8'hAA);
        send(8'hBB);
        send(8'hCC);
        bus.cs_n = 1'b1;
        tick();
        check("abort.oe", 64'(bus.dq_oe), 64'd0);
        check("abort.done", 64'(bus.frame_done), 64'd0);
        tick();
        check("abort.done2", 64'(bus.frame_done), 64'd0);
        rd_frame("rd_post_abort", 32'h0000_0010, 8'h00, 64'h01234567_89ABCDEF);

        // Unknown command: target stays silent until deselected.
        aug = 8'h00;
        send(8'h9F);
        for (int i = 0; i < 14; i++) begin
            send(8'h55);
            check("ign.oe", 64'(bus.dq_oe), 64'd0);
            check("ign.done", 64'(bus.frame_done), 64'd0);
            check("ign.err", 64'(bus.crc_err), 64'd0);
        end
        bus.cs_n = 1'b1;
        tick();
        rd_frame("rd_post_ign", 32'h0000_0008, 8'h00, 64'hDEADBEEF_CAFEBABE);

        // Reset in the middle of read data.
        send_hdr(8'h0B, 32'h0000_0008);
        send_crc(8'h00);
        tick();
        tick();
        check("rr.stat", 64'(bus.dq_out), 64'hA5);
        tick();
        check("rr.b0", 64'(bus.dq_out), 64'hDE);
        tick();
        check("rr.b1", 64'(bus.dq_out), 64'hAD);
        rst = 1'b0;
        tick();
        exp_cnt = 8'h00;
        check("rr.oe", 64'(bus.dq_oe), 64'd0);
        check("rr.out", 64'(bus.dq_out), 64'd0);
        check("rr.cnt", 64'(bus.crc_err_cnt), 64'd0);
        check("rr.done", 64'(bus.frame_done), 64'd0);
        rst      = 1'b1;
        bus.cs_n = 1'b1;
        tick();
        rd_frame("rd_post_rst", 32'h0000_0008, 8'h00, 64'hDEADBEEF_CAFEBABE);
        rd_frame("rd_bad_post_rst", 32'h0000_0008, 8'h04, 64'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/xspi_8s_crc_target.md
Name: xspi_8s_crc_target

Overview:
- Octal-SPI (8S-8S-8S) target/responder: the far end of the TileLink-UL-to-xSPI bridge.
- Receives command, address and write data one byte per clk beat while cs_n is low, and checks a trailing CRC-8.
- Drives an ACK or NAK status byte so the bridge can retransmit, then serves reads from an internal 64-bit word memory.
- Serves as both the bridge's simulation/FPGA memory target and a standalone slave.

Parameters:
- ADDR_BYTES, 4, address bytes per frame, sent MSB first.
- DATA_BYTES, 8, data bytes per frame, i.e. one 64-bit word.
- DEPTH, 512, memory words; index = addr[3 +: log2(DEPTH)], wraps modulo DEPTH.
- DUMMY_CYCLES, 2, turnaround beats between the last host byte and the first target-driven byte; must be ≥1.
- ACK_BYTE, 8'hA5, status byte returned for a good CRC.
- NAK_BYTE, 8'h5A, status byte returned for a bad CRC.

Ports:
- clk  in  1  single clock; bus beats sampled on posedge.
- rst  in  1  synchronous reset, active-low (0 = reset), sampled on posedge clk.
- cs_n  in  1  frame select, active-low.
- dq_in  in  8  host-driven byte, valid each beat while cs_n=0 and dq_oe=0.
- dq_out  out  8  target-driven byte.
- dq_oe  out  1  target drive enable.
- frame_done  out  1  one-cycle pulse when a frame completes normally.
- crc_err  out  1  one-cycle pulse when a received CRC mismatches.
- crc_err_cnt  out  8  saturating count of CRC mismatches.

Behaviour:
- Reset (rst=0 at posedge): state=IDLE; dq_out=0, dq_oe=0, frame_done=0, crc_err=0, crc_err_cnt=0. Memory contents are not cleared.
- CRC-8: poly 0x07, init 0x00, no reflection, no final xor; processed MSB-first per byte.
- Command byte: 8'h02 = WRITE, 8'h0B = READ; any other value is treated as unknown.
- WRITE frame from host: cmd, ADDR_BYTES addr, DATA_BYTES data (MSB byte first), crc. CRC covers cmd+addr+data.
- READ frame from host: cmd, addr, crc. CRC covers cmd+addr.
- IDLE:
  - cs_n=0 → capture dq_in as cmd and start the CRC.
  - Known cmd → ADDR; unknown cmd → IGNORE.
- ADDR: shift in ADDR_BYTES beats.
  - WRITE → WDATA (DATA_BYTES beats) → RXCRC.
  - READ → RXCRC.
- RXCRC: compare the received byte with the running CRC.
  - Mismatch → set crc_err pulse next cycle; crc_err_cnt +1, saturating at 255.
  - Always → TURN.
- TURN: DUMMY_CYCLES beats with dq_oe=0, then STATUS.
- STATUS: dq_oe=1, dq_out = ACK_BYTE or NAK_BYTE for one beat.
  - WRITE+ACK: memory word written in the STATUS cycle.
  - NAK: memory is not modified.
  - Next state: READ+ACK → RDATA; otherwise → DONE.
- RDATA: drive DATA_BYTES beats of mem[idx], MSB byte first, then TXCRC.
  - The word is latched at the ACK so a concurrent change cannot tear it.
- TXCRC: drive the CRC-8 of the driven data bytes for one beat → DONE.
- DONE: dq_oe=0; frame_done pulses on entry; wait for cs_n=1 → IDLE.
- IGNORE: dq_oe=0; no frame_done; wait for cs_n=1 → IDLE.
- cs_n rising in any state other than IDLE/DONE (abort):
  - Next cycle: IDLE, dq_oe=0.
  - No memory write, no frame_done, no crc_err.
- Extra beats after DONE while cs_n is still low are ignored.
- A new frame requires cs_n=1 for at least one cycle.
- dq_out/dq_oe are registered; the first driven beat is exactly 1+DUMMY_CYCLES cycles after the cycle the host CRC byte was sampled.
- Reset mid-frame: immediate IDLE at that posedge; any partially received write is discarded.

Test Plan:
- Write, good CRC: cmd 02, addr 00000008, data DEADBEEFCAFEBABE, correct CRC → dq_oe rises 3 cycles after the CRC beat with dq_out=A5; mem[1]=DEADBEEFCAFEBABE; one frame_done pulse.
- Read-back: cmd 0B, addr 00000008, correct CRC → A5, then DE AD BE EF CA FE BA BE, then a CRC byte matching the bench CRC-8 model; dq_oe=0 after.
- Bad CRC write: as the first case with the CRC byte xor 01 → status 5A; crc_err pulses; crc_err_cnt=1; mem[1] unchanged. Retransmit with the correct CRC → A5, word written.
- Read with bad CRC → single 5A, no data beats, frame_done pulses; 256 bad frames → crc_err_cnt holds at FF.
- Abort: cs_n raised after 3 data bytes of a write → no write, no frame_done; the next frame works normally. Unknown cmd 9F → dq_oe stays 0 until cs_n high.
- rst=0 during the RDATA beat → dq_oe=0 and IDLE at that posedge; crc_err_cnt=0; mem[1] retains DEADBEEFCAFEBABE.
